// File: rtl/uart_rx_packet_ctrl.sv
// UART packet sequencer: SYNC, LEN, payload, XOR CHK -> buffered valid/ready byte stream.
// Optional UART_PKT_STATS_EN adds saturating pkt_cnt / err_cnt outputs.
module uart_rx_packet_ctrl #(
  parameter int         CLK_FREQ     = 50_000_000,
  parameter int         BAUD_RATE    = 9600,
  parameter logic [7:0] SYNC_BYTE    = 8'h55,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_flag,
  input  logic [7:0] rx_data,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  output logic       pkt_last,
  input  logic       pkt_ready,
  output logic [7:0] pkt_len,
  output logic       busy,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_timeout,
  output logic       err_overrun
`ifdef UART_PKT_STATS_EN
  ,
  output logic [15:0] pkt_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam int TO_CYC = (CLK_FREQ / BAUD_RATE) * TIMEOUT_BITS;
  localparam int TW = $clog2(TO_CYC + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHECK,
    S_DRAIN
  } state_t;

  state_t        state_q;
  logic          rx_flag_q;
  logic          byte_stb;
  logic          in_frame;
  logic          to_hit;
  logic          enter_drain;
  logic [7:0]    len_q;
  logic [7:0]    idx_q;
  logic [7:0]    idx_nxt;
  logic [7:0]    chk_q;
  logic [TW-1:0] timer_q;
  logic [7:0]    mem_q [MAX_LEN];

  assign byte_stb    = rx_flag & ~rx_flag_q;
  assign in_frame    = (state_q == S_LEN) || (state_q == S_PAYLOAD)
                    || (state_q == S_CHECK);
  assign to_hit      = (timer_q == TO_LAST);
  assign idx_nxt     = idx_q + 8'd1;
  assign enter_drain = (state_q == S_CHECK) && byte_stb && (rx_data == chk_q);
  assign busy        = (state_q != S_IDLE);
  assign pkt_len     = len_q;

  // payload storage carries no reset; only indices guard its contents
  always_ff @(posedge clk) begin
    if (state_q == S_PAYLOAD && byte_stb)
      mem_q[idx_q[IW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rx_flag_q   <= 1'b0;
      len_q       <= '0;
      idx_q       <= '0;
      chk_q       <= '0;
      timer_q     <= '0;
      pkt_data    <= '0;
      pkt_valid   <= 1'b0;
      pkt_last    <= 1'b0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      rx_flag_q   <= rx_flag;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      // a byte arriving on the expiry cycle wins over the timeout
      if (!in_frame || byte_stb)
        timer_q <= '0;
      else
        timer_q <= timer_q + TW'(1);
      unique case (state_q)
        S_IDLE: begin
          if (byte_stb && rx_data == SYNC_BYTE)
            state_q <= S_LEN;
        end
        S_LEN: begin
          if (byte_stb) begin
            if (rx_data == 8'd0 || int'(rx_data) > MAX_LEN) begin
              err_len <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              len_q   <= rx_data;
              chk_q   <= rx_data;
              idx_q   <= '0;
              state_q <= S_PAYLOAD;
            end
          end else if (to_hit) begin
            err_timeout <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        S_PAYLOAD: begin
          if (byte_stb) begin
            chk_q <= chk_q ^ rx_data;
            idx_q <= idx_nxt;
            if (idx_nxt == len_q)
              state_q <= S_CHECK;
          end else if (to_hit) begin
            err_timeout <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        S_CHECK: begin
          if (byte_stb) begin
            if (enter_drain) begin
              idx_q     <= '0;
              pkt_valid <= 1'b1;
              pkt_data  <= mem_q[0];
              pkt_last  <= (len_q == 8'd1);
              state_q   <= S_DRAIN;
            end else begin
              err_chk <= 1'b1;
              state_q <= S_IDLE;
            end
          end else if (to_hit) begin
            err_timeout <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (byte_stb)
            err_overrun <= 1'b1;
          if (pkt_ready) begin
            if (pkt_last) begin
              pkt_valid <= 1'b0;
              pkt_last  <= 1'b0;
              state_q   <= S_IDLE;
            end else begin
              idx_q    <= idx_nxt;
              pkt_data <= mem_q[idx_nxt[IW-1:0]];
              pkt_last <= (idx_nxt == len_q - 8'd1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef UART_PKT_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (enter_drain && pkt_cnt != 16'hFFFF)
        pkt_cnt <= pkt_cnt + 16'd1;
      if ((err_chk | err_len | err_timeout | err_overrun)
          && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
